jtframe_rom_arb: RTL and testbench

Parametrised ROM request arbiter between N game-side ROM slots and the single SDRAM ROM port of the frame (`sdram_req`/`sdram_ack`/`data_read`/`data_rdy`). It replaces the one-requester connection with a configurable slot count and selectable arbitration mode. It adds a one-word cache per slot so repeated reads hit without SDRAM traffic, and blocks requests during ROM download. It sits in the game top, between the game's ROM consumers and `jtframe_mist`.

---
 rtl/jtframe_rom_arb_if.sv | 27 ++
 rtl/jtframe_rom_arb.sv | 134 +++++++++++++
 tb/tb_jtframe_rom_arb.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/jtframe_rom_arb_if.sv
// Bus bundle between the ROM slots, the arbiter and the SDRAM ROM port.
// The master modport is the arbiter side.
interface jtframe_rom_arb_if #(
  parameter int unsigned SLOTS = 4,
  parameter int unsigned AW    = 22,
  parameter int unsigned DW    = 32
);
  logic [SLOTS-1:0]    slot_cs;
  logic [SLOTS*AW-1:0] slot_addr;
  logic [SLOTS-1:0]    slot_ok;
  logic [SLOTS*DW-1:0] slot_dout;
  logic                sdram_req;
  logic [AW-1:0]       sdram_addr;
  logic                sdram_ack;
  logic [DW-1:0]       data_read;
  logic                data_rdy;

  modport master (
    input  slot_cs, slot_addr, sdram_ack, data_read, data_rdy,
    output slot_ok, slot_dout, sdram_req, sdram_addr
  );

  modport slave (
    output slot_cs, slot_addr, sdram_ack, data_read, data_rdy,
    input  slot_ok, slot_dout, sdram_req, sdram_addr
  );
endinterface

// File: rtl/jtframe_rom_arb.sv
// ROM request arbiter: N cached read slots sharing one SDRAM ROM port.
// Round-robin or fixed-priority selection; caches invalidated while downloading.
module jtframe_rom_arb #(
  parameter int unsigned SLOTS = 4,
  parameter int unsigned AW    = 22,
  parameter int unsigned DW    = 32,
  parameter int unsigned PRIO  = 0
) (
  input  logic               clk_rom,
  input  logic               rst,
  input  logic               downloading,
  jtframe_rom_arb_if.master  bus
);
  localparam int unsigned IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]          state_q,   state_d;
  logic                req_q,     req_d;
  logic [AW-1:0]       addr_q,    addr_d;
  logic [SLOTS-1:0]    ok_q,      ok_d;
  logic [SLOTS*DW-1:0] dout_q,    dout_d;
  logic [SLOTS-1:0]    valid_q,   valid_d;
  logic [SLOTS*AW-1:0] caddr_q,   caddr_d;
  logic [IW-1:0]       rr_q,      rr_d;
  logic [IW-1:0]       win_q,     win_d;
  logic                dl_seen_q, dl_seen_d;

  logic [SLOTS-1:0]    hit, miss;
  logic                found;
  logic [IW-1:0]       sel;

  assign bus.sdram_req  = req_q;
  assign bus.sdram_addr = addr_q;
  assign bus.slot_ok    = ok_q;
  assign bus.slot_dout  = dout_q;

  // Cache lookup per slot
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      hit[i] = bus.slot_cs[i] & valid_q[i] &
               (caddr_q[i*AW +: AW] == bus.slot_addr[i*AW +: AW]);
    end
    miss = bus.slot_cs & ~hit & {SLOTS{~downloading}};
  end

  // Winner search: from slot 0 (fixed) or from rr pointer with wrap
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int unsigned k = 0; k < SLOTS; k++) begin
      int unsigned j;
      j = (PRIO != 0) ? k : ((32'(rr_q) + k) % SLOTS);
      if (!found && miss[IW'(j)]) begin
        found = 1'b1;
        sel   = IW'(j);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    addr_d    = addr_q;
    ok_d      = hit;
    dout_d    = dout_q;
    valid_d   = valid_q;
    caddr_d   = caddr_q;
    rr_d      = rr_q;
    win_d     = win_q;
    dl_seen_d = dl_seen_q;
    if (downloading) valid_d = '0;
    case (state_q)
      ST_IDLE: begin
        dl_seen_d = 1'b0;
        if (found) begin
          win_d   = sel;
          addr_d  = bus.slot_addr[32'(sel)*AW +: AW];
          req_d   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (downloading) dl_seen_d = 1'b1;
        if (bus.sdram_ack) begin
          req_d   = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (downloading) dl_seen_d = 1'b1;
        if (bus.data_rdy) begin
          // Data is filed under the address that was actually requested
          caddr_d[32'(win_q)*AW +: AW] = addr_q;
          dout_d[32'(win_q)*DW +: DW]  = bus.data_read;
          valid_d[win_q]               = ~(dl_seen_q | downloading);
          rr_d      = (win_q == IW'(SLOTS-1)) ? '0 : win_q + IW'(1);
          dl_seen_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_rom) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      req_q     <= 1'b0;
      addr_q    <= '0;
      ok_q      <= '0;
      dout_q    <= '0;
      valid_q   <= '0;
      caddr_q   <= '0;
      rr_q      <= '0;
      win_q     <= '0;
      dl_seen_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      ok_q      <= ok_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      caddr_q   <= caddr_d;
      rr_q      <= rr_d;
      win_q     <= win_d;
      dl_seen_q <= dl_seen_d;
    end
  end
endmodule

// File: tb/tb_jtframe_rom_arb.sv
// Directed bench for jtframe_rom_arb: a round-robin instance and a fixed-priority one.
module tb_jtframe_rom_arb;
  logic clk = 1'b0;
  logic rst;
  logic dl0, dl1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  jtframe_rom_arb_if #(.SLOTS(4), .AW(22), .DW(32)) bus0 ();
  jtframe_rom_arb_if #(.SLOTS(4), .AW(22), .DW(32)) bus1 ();

  jtframe_rom_arb #(.SLOTS(4), .AW(22), .DW(32), .PRIO(0)) dut0 (
    .clk_rom(clk), .rst(rst), .downloading(dl0), .bus(bus0));
  jtframe_rom_arb #(.SLOTS(4), .AW(22), .DW(32), .PRIO(1)) dut1 (
    .clk_rom(clk), .rst(rst), .downloading(dl1), .bus(bus1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    bus0.slot_cs = '0; bus0.slot_addr = '0; bus0.sdram_ack = 1'b0;
    bus0.data_rdy = 1'b0; bus0.data_read = '0;
    bus1.slot_cs = '0; bus1.slot_addr = '0; bus1.sdram_ack = 1'b0;
    bus1.data_rdy = 1'b0; bus1.data_read = '0;
    dl0 = 1'b0; dl1 = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Controller model: wait for a request, ack it, return data a cycle later
  task automatic serve0(input logic [31:0] data, output logic [21:0] a, output bit to);
    to = 1'b1; a = '0;
    for (int n = 0; n < 30; n++) begin
      if (bus0.sdram_req) begin to = 1'b0; break; end
      tick();
    end
    if (!to) begin
      a = bus0.sdram_addr;
      bus0.sdram_ack = 1'b1; tick(); bus0.sdram_ack = 1'b0; tick();
      bus0.data_read = data; bus0.data_rdy = 1'b1; tick(); bus0.data_rdy = 1'b0;
    end
  endtask

  task automatic serve1(input logic [31:0] data, output logic [21:0] a, output bit to);
    to = 1'b1; a = '0;
    for (int n = 0; n < 30; n++) begin
      if (bus1.sdram_req) begin to = 1'b0; break; end
      tick();
    end
    if (!to) begin
      a = bus1.sdram_addr;
      bus1.sdram_ack = 1'b1; tick(); bus1.sdram_ack = 1'b0; tick();
      bus1.data_read = data; bus1.data_rdy = 1'b1; tick(); bus1.data_rdy = 1'b0;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++; if (bus0.sdram_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", bus0.sdram_req); end
    n_tests++; if (bus0.sdram_addr !== 22'h0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", bus0.sdram_addr); end
    n_tests++; if (bus0.slot_ok !== 4'h0) begin n_fail++; $display("FAIL reset_ok got %b exp 0000", bus0.slot_ok); end
    n_tests++; if (bus0.slot_dout !== 128'h0) begin n_fail++; $display("FAIL reset_dout got %h exp 0", bus0.slot_dout); end
  endtask

  task automatic test_miss_fill();
    bus0.slot_cs[2] = 1'b1; bus0.slot_addr[2*22 +: 22] = 22'h1234;
    tick();
    n_tests++; if (bus0.sdram_req !== 1'b1) begin n_fail++; $display("FAIL miss_req got %b exp 1", bus0.sdram_req); end
    n_tests++; if (bus0.sdram_addr !== 22'h1234) begin n_fail++; $display("FAIL miss_addr got %h exp 1234", bus0.sdram_addr); end
    bus0.sdram_ack = 1'b1; tick(); bus0.sdram_ack = 1'b0;
    n_tests++; if (bus0.sdram_req !== 1'b0) begin n_fail++; $display("FAIL ack_drop got %b exp 0", bus0.sdram_req); end
    tick();
    bus0.data_read = 32'hDEADBEEF; bus0.data_rdy = 1'b1; tick(); bus0.data_rdy = 1'b0;
    n_tests++; if (bus0.slot_dout[2*32 +: 32] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fill_dout got %h exp deadbeef", bus0.slot_dout[2*32 +: 32]); end
    n_tests++; if (bus0.slot_ok[2] !== 1'b0) begin n_fail++; $display("FAIL fill_ok_early got %b exp 0", bus0.slot_ok[2]); end
    tick();
    n_tests++; if (bus0.slot_ok !== 4'b0100) begin n_fail++; $display("FAIL fill_ok got %b exp 0100", bus0.slot_ok); end
    n_tests++; if (bus0.sdram_req !== 1'b0) begin n_fail++; $display("FAIL hit_no_req got %b exp 0", bus0.sdram_req); end
  endtask

  task automatic test_hit_readdr();
    logic [21:0] a; bit to;
    bus0.slot_cs[2] = 1'b0; tick();
    n_tests++; if (bus0.slot_ok[2] !== 1'b0) begin n_fail++; $display("FAIL cs_low_ok got %b exp 0", bus0.slot_ok[2]); end
    bus0.slot_cs[2] = 1'b1; tick();
    n_tests++; if (bus0.slot_ok[2] !== 1'b1 || bus0.sdram_req !== 1'b0) begin n_fail++; $display("FAIL rehit got ok=%b req=%b exp ok=1 req=0", bus0.slot_ok[2], bus0.sdram_req); end
    bus0.slot_addr[2*22 +: 22] = 22'h1235; tick();
    n_tests++; if (bus0.slot_ok[2] !== 1'b0) begin n_fail++; $display("FAIL newaddr_ok got %b exp 0", bus0.slot_ok[2]); end
    n_tests++; if (bus0.sdram_req !== 1'b1 || bus0.sdram_addr !== 22'h1235) begin n_fail++; $display("FAIL newaddr_req got req=%b addr=%h exp req=1 addr=1235", bus0.sdram_req, bus0.sdram_addr); end
    serve0(32'h0BADF00D, a, to);
    tick();
    n_tests++; if (to || bus0.slot_ok[2] !== 1'b1 || bus0.slot_dout[2*32 +: 32] !== 32'h0BADF00D) begin n_fail++; $display("FAIL newaddr_fill got to=%b ok=%b dout=%h exp to=0 ok=1 dout=0badf00d", to, bus0.slot_ok[2], bus0.slot_dout[2*32 +: 32]); end
  endtask

  task automatic test_round_robin();
    logic [21:0] got [5];
    logic [21:0] exp [5];
    bit to;
    exp[0] = 22'h100; exp[1] = 22'h101; exp[2] = 22'h102; exp[3] = 22'h103; exp[4] = 22'h200;
    apply_reset();
    for (int i = 0; i < 4; i++) bus0.slot_addr[i*22 +: 22] = 22'(32'h100 + i);
    bus0.slot_cs = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      if (k == 3) bus0.slot_addr[0 +: 22] = 22'h200;
      serve0(32'hA0000000 | 32'(k), got[k], to);
      n_tests++; if (to || got[k] !== exp[k]) begin n_fail++; $display("FAIL rr_order[%0d] got %h to=%b exp %h", k, got[k], to, exp[k]); end
    end
    tick();
    n_tests++; if (bus0.slot_ok !== 4'b1111) begin n_fail++; $display("FAIL rr_all_ok got %b exp 1111", bus0.slot_ok); end
    n_tests++; if (bus0.slot_dout[0 +: 32] !== 32'hA0000004 || bus0.slot_dout[3*32 +: 32] !== 32'hA0000003) begin n_fail++; $display("FAIL rr_dout got s0=%h s3=%h exp a0000004 a0000003", bus0.slot_dout[0 +: 32], bus0.slot_dout[3*32 +: 32]); end
  endtask

  task automatic test_priority();
    logic [21:0] got [5];
    logic [21:0] exp [5];
    bit to;
    exp[0] = 22'h100; exp[1] = 22'h101; exp[2] = 22'h102; exp[3] = 22'h200; exp[4] = 22'h103;
    apply_reset();
    for (int i = 0; i < 4; i++) bus1.slot_addr[i*22 +: 22] = 22'(32'h100 + i);
    bus1.slot_cs = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      if (k == 3) bus1.slot_addr[0 +: 22] = 22'h200;
      serve1(32'hB0000000 | 32'(k), got[k], to);
      n_tests++; if (to || got[k] !== exp[k]) begin n_fail++; $display("FAIL prio_order[%0d] got %h to=%b exp %h", k, got[k], to, exp[k]); end
    end
  endtask

  task automatic test_download();
    logic [21:0] a; bit to; bit bad;
    apply_reset();
    bus0.slot_cs[0] = 1'b1; bus0.slot_addr[0 +: 22] = 22'h10;
    serve0(32'h11111111, a, to);
    tick();
    n_tests++; if (to || bus0.slot_ok[0] !== 1'b1) begin n_fail++; $display("FAIL dl_pre_hit got ok=%b to=%b exp ok=1", bus0.slot_ok[0], to); end
    bus0.slot_cs[1] = 1'b1; bus0.slot_addr[1*22 +: 22] = 22'h20;
    tick();
    bus0.sdram_ack = 1'b1; tick(); bus0.sdram_ack = 1'b0;
    dl0 = 1'b1; tick(); dl0 = 1'b0; tick();
    n_tests++; if (bus0.slot_ok[0] !== 1'b0) begin n_fail++; $display("FAIL dl_hit_drop got %b exp 0", bus0.slot_ok[0]); end
    bus0.data_read = 32'h22222222; bus0.data_rdy = 1'b1; tick(); bus0.data_rdy = 1'b0;
    n_tests++; if (bus0.slot_dout[1*32 +: 32] !== 32'h22222222) begin n_fail++; $display("FAIL dl_fill_dout got %h exp 22222222", bus0.slot_dout[1*32 +: 32]); end
    dl0 = 1'b1;
    bad = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick();
      if (bus0.sdram_req !== 1'b0 || bus0.slot_ok !== 4'b0000) bad = 1'b1;
    end
    n_tests++; if (bad) begin n_fail++; $display("FAIL dl_block got req=%b ok=%b exp req=0 ok=0000", bus0.sdram_req, bus0.slot_ok); end
    dl0 = 1'b0; tick();
    n_tests++; if (bus0.sdram_req !== 1'b1 || bus0.sdram_addr !== 22'h10) begin n_fail++; $display("FAIL dl_resume got req=%b addr=%h exp req=1 addr=10", bus0.sdram_req, bus0.sdram_addr); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus0.slot_cs[1] = 1'b1; bus0.slot_addr[1*22 +: 22] = 22'h30;
    tick();
    n_tests++; if (bus0.sdram_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_req got %b exp 1", bus0.sdram_req); end
    rst = 1'b1; tick();
    n_tests++; if (bus0.sdram_req !== 1'b0 || bus0.slot_ok !== 4'b0000) begin n_fail++; $display("FAIL rstmid_clear got req=%b ok=%b exp 0 0000", bus0.sdram_req, bus0.slot_ok); end
    rst = 1'b0; bus0.slot_cs = '0;
    bus0.data_read = 32'hCAFEF00D; bus0.data_rdy = 1'b1; tick(); bus0.data_rdy = 1'b0;
    tick();
    n_tests++; if (bus0.slot_dout !== 128'h0) begin n_fail++; $display("FAIL rstmid_stray got %h exp 0", bus0.slot_dout); end
  endtask

  task automatic test_addr_change();
    apply_reset();
    bus0.slot_cs[3] = 1'b1; bus0.slot_addr[3*22 +: 22] = 22'h300;
    tick();
    bus0.sdram_ack = 1'b1; tick(); bus0.sdram_ack = 1'b0;
    bus0.slot_addr[3*22 +: 22] = 22'h301; tick();
    bus0.data_read = 32'h33333333; bus0.data_rdy = 1'b1; tick(); bus0.data_rdy = 1'b0;
    n_tests++; if (bus0.slot_dout[3*32 +: 32] !== 32'h33333333) begin n_fail++; $display("FAIL chg_dout got %h exp 33333333", bus0.slot_dout[3*32 +: 32]); end
    tick();
    n_tests++; if (bus0.slot_ok[3] !== 1'b0) begin n_fail++; $display("FAIL chg_ok got %b exp 0", bus0.slot_ok[3]); end
    n_tests++; if (bus0.sdram_req !== 1'b1 || bus0.sdram_addr !== 22'h301) begin n_fail++; $display("FAIL chg_rereq got req=%b addr=%h exp req=1 addr=301", bus0.sdram_req, bus0.sdram_addr); end
    bus0.slot_addr[3*22 +: 22] = 22'h300; tick();
    n_tests++; if (bus0.slot_ok[3] !== 1'b1 || bus0.sdram_addr !== 22'h301) begin n_fail++; $display("FAIL chg_old_cached got ok=%b addr=%h exp ok=1 addr=301", bus0.slot_ok[3], bus0.sdram_addr); end
    bus0.slot_cs = '0;
  endtask

  initial begin
    test_reset();
    test_miss_fill();
    test_hit_readdr();
    test_round_robin();
    test_priority();
    test_download();
    test_reset_mid();
    test_addr_change();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
